comp_serial: RTL

Sequential magnitude comparator. It sits directly upstream of the 2-bit equal/greater/less compare stage and generalises it to WIDTH-bit operands. Operands are captured on a start handshake, then scanned MSB-first, one 2-bit digit pair per clock. It reports equal/greater/less on the same x/y/z convention as the 2-bit stage, with a one-cycle done strobe.

---
 rtl/comp_serial.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/comp_serial.sv
// rtl/comp_serial.sv - sequential MSB-first magnitude comparator, one 2-bit digit per clock
//
// Purpose:
//   Captures operands A/B on an accepted start and scans them MSB-first, one
//   2-bit digit pair per cycle. It reports equal/greater/less on x/y/z and
//   raises a one-cycle done strobe.
//
// Optional build macro:
//   COMP_EARLY_EXIT_EN - stop scanning on the first differing digit
//                        (data-dependent latency 1..D). If this macro is
//                        undefined, the latency is always D cycles.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - synchronous active-high reset, highest priority
//   i_start  - compare request, ignored while scanning
//   i_a, i_b - WIDTH-bit unsigned operands, captured on the accepting edge
//   o_busy   - high while scanning
//   o_done   - one-cycle strobe after the resolution edge
//   o_x      - A == B (held until the next resolution)
//   o_y      - A >  B
//   o_z      - A <  B

module comp_serial #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_x,
  output logic             o_y,
  output logic             o_z
);

  localparam int D  = WIDTH / 2;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_gt;
  logic             r_lt;
  logic             r_x;
  logic             r_y;
  logic             r_z;

  logic [1:0]       w_da;
  logic [1:0]       w_db;
  logic             w_gt_n;
  logic             w_lt_n;
  logic             w_last;
  logic             w_resolve;
  logic             w_accept;

  assign w_da     = r_sa[WIDTH-1:WIDTH-2];
  assign w_db     = r_sb[WIDTH-1:WIDTH-2];
  assign w_last   = (r_cnt == '0);
  assign w_accept = i_start && (r_state != SCAN);

  // Sticky flags: once either flag is set, later digits cannot change it.
  // This keeps the most-significant difference as the result.
  assign w_gt_n = r_gt | (~(r_gt | r_lt) & (w_da > w_db));
  assign w_lt_n = r_lt | (~(r_gt | r_lt) & (w_da < w_db));

`ifdef COMP_EARLY_EXIT_EN
  assign w_resolve = w_last | w_gt_n | w_lt_n;
`else
  assign w_resolve = w_last;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = SCAN;
      SCAN:    if (w_resolve) w_next = DONE;
      DONE:    w_next = i_start ? SCAN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_cnt <= '0;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
      r_x   <= 1'b0;
      r_y   <= 1'b0;
      r_z   <= 1'b0;
    end else if (w_accept) begin
      // The x/y/z outputs keep the previous result until the new compare resolves.
      r_sa  <= i_a;
      r_sb  <= i_b;
      r_cnt <= CW'(D - 1);
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (r_state == SCAN) begin
      r_sa <= r_sa << 2;
      r_sb <= r_sb << 2;
      r_gt <= w_gt_n;
      r_lt <= w_lt_n;
      if (!w_last) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_resolve) begin
        r_x <= ~(w_gt_n | w_lt_n);
        r_y <= w_gt_n;
        r_z <= w_lt_n;
      end
    end
  end

  assign o_busy = (r_state == SCAN);
  assign o_done = (r_state == DONE);
  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_z    = r_z;

endmodule
